// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline (load-use, branch, mul/div, dmem wait).
// Optional macro PIPE_PERF_CNT_EN adds 32-bit stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        exe_MemRead,
  input  logic [4:0]  exe_wreg,
  input  logic        exe_md_start,
  input  logic        branch_taken,
  input  logic        dmem_stall,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_exe_en,
  output logic        id_exe_flush,
  output logic        exe_mem_en,
  output logic        exe_mem_flush,
  output logic        md_busy,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic {
    RUN = 1'b0,
    MD  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] MD_RELOAD = CNT_W'(MD_LAT - 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_hazard;

  assign load_hazard = id_valid & exe_MemRead & (exe_wreg != 5'd0) &
                       ((exe_wreg == id_rs) | (id_uses_rt & (exe_wreg == id_rt)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_en     = 1'b1;
    id_exe_flush  = 1'b0;
    exe_mem_en    = 1'b1;
    exe_mem_flush = 1'b0;
    md_busy       = 1'b0;

    if (!rst) begin
      state_d    = RUN;
      cnt_d      = '0;
      pc_en      = 1'b0;
      if_id_en   = 1'b0;
      id_exe_en  = 1'b0;
      exe_mem_en = 1'b0;
    end else begin
      md_busy = (state_q == MD);
      if (dmem_stall) begin
        pc_en      = 1'b0;
        if_id_en   = 1'b0;
        id_exe_en  = 1'b0;
        exe_mem_en = 1'b0;
      end else if ((state_q == MD) && (cnt_q != '0)) begin
        // Mul/div still occupying EXE: freeze upstream, bubble downstream.
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_exe_en     = 1'b0;
        exe_mem_en    = 1'b0;
        exe_mem_flush = 1'b1;
        cnt_d         = cnt_q - 1'b1;
      end else begin
        // RUN, or the MD release cycle which follows RUN rules.
        state_d = RUN;
        if (branch_taken) begin
          if_id_en     = 1'b0;
          if_id_flush  = 1'b1;
          id_exe_en    = 1'b0;
          id_exe_flush = 1'b1;
        end else if (exe_md_start) begin
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          id_exe_en     = 1'b0;
          exe_mem_en    = 1'b0;
          exe_mem_flush = 1'b1;
          state_d       = MD;
          cnt_d         = MD_RELOAD;
        end else if (load_hazard) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_exe_en    = 1'b0;
          id_exe_flush = 1'b1;
        end
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en)      stall_cnt_q <= stall_cnt_q + 32'd1;
      if (if_id_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
